// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] ANODE_OFF  = 4'hF;

  // Active-low a..g patterns (bit6=a ... bit0=g), indexed by nibble value.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, SEG_BLANK,  SEG_BLANK,
    SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  // Scan position: which digit slot is active and which phase of the slot we are in.
  typedef struct packed {
    logic [1:0]  dig_idx;
    scan_state_t state;
  } scan_dbg_t;

endpackage

// File: rtl/seg_bcd_decode.sv
// Nibble plus decimal point to active-low segment byte {dp, a..g}.
module seg_bcd_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  assign o_seg = {~i_dp, SEG_LUT[i_nibble]};

endmodule

// File: rtl/seg_scan_scheduler.sv
// Four-digit multiplex scan with per-slot blanking, PWM brightness and a
// single-entry write buffer that is committed only at frame boundaries.
//
// Write handshake: a write is accepted on any cycle where wr_en=1 and
// wr_ready=1; wr_ready drops the next cycle and rises again the cycle after
// the frame_tick that commits the buffer. wr_en while wr_ready=0 is ignored.
module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter int BLANK_CYCLES = 4,
  parameter int STEP_CYCLES  = 3125
) (
  input  logic        m_clk,
  input  logic        Reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic [3:0]  wr_en_dig,
  input  logic [3:0]  brightness,
  output logic        wr_ready,
  output logic [3:0]  vcc,
  output logic [7:0]  counter,
  output logic        frame_tick,
  output scan_dbg_t   o_dbg
);

  localparam int ON_CYCLES   = 16 * STEP_CYCLES;
  localparam int SLOT_CYCLES = BLANK_CYCLES + ON_CYCLES;
  localparam int CW          = $clog2(SLOT_CYCLES);
  localparam int DW          = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  logic [CW-1:0] r_slot_cnt, w_slot_nxt;
  logic [DW-1:0] r_dig_idx, w_dig_nxt;
  scan_state_t   r_state, w_state_nxt;
  logic          w_slot_wrap;

  logic [3:0]    r_bri;
  logic [15:0]   r_act_data, r_pend_data;
  logic [3:0]    r_act_dp, r_act_en, r_pend_dp, r_pend_en;
  logic          r_wr_ready;
  logic [3:0]    r_vcc, w_vcc_nxt;
  logic [7:0]    r_counter, w_counter_nxt;
  logic          r_frame_tick, w_ftick_nxt;

  logic [31:0]   w_on_cnt, w_lit_lim;
  logic          w_lit;
  logic [3:0]    w_nibble;
  logic [7:0]    w_seg;

  // Scan position and phase register.
  always_ff @(posedge m_clk) begin
    if (Reset) begin
      r_slot_cnt <= '0;
      r_dig_idx  <= '0;
      r_state    <= ST_BLANK;
    end else begin
      r_slot_cnt <= w_slot_nxt;
      r_dig_idx  <= w_dig_nxt;
      r_state    <= w_state_nxt;
    end
  end

  // Next scan position; phase is BLANK for the first BLANK_CYCLES of every slot.
  always_comb begin
    w_slot_wrap = (r_slot_cnt == SLOT_LAST);
    w_slot_nxt  = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
    w_dig_nxt   = w_slot_wrap ? r_dig_idx + 1'b1 : r_dig_idx;
    w_state_nxt = (w_slot_nxt < BLANK_END) ? ST_BLANK : ST_ON;
  end

  seg_bcd_decode u_dec (
    .i_nibble (w_nibble),
    .i_dp     (r_act_dp[r_dig_idx]),
    .o_seg    (w_seg)
  );

  // Pin values for the current scan position; registered below, so pins lag by one cycle.
  always_comb begin
    w_nibble      = r_act_data[{r_dig_idx, 2'b00} +: 4];
    w_on_cnt      = 32'(r_slot_cnt) - 32'(BLANK_CYCLES);
    w_lit_lim     = (32'(r_bri) + 32'd1) * 32'(STEP_CYCLES);
    w_lit         = (r_state == ST_ON) && (w_on_cnt < w_lit_lim) && r_act_en[r_dig_idx];
    w_vcc_nxt     = ANODE_OFF;
    w_counter_nxt = 8'hFF;
    if (w_lit) begin
      w_vcc_nxt     = ~(4'b0001 << r_dig_idx);
      w_counter_nxt = w_seg;
    end
    w_ftick_nxt   = (r_dig_idx == DIG_LAST) && w_slot_wrap;
  end

  // Brightness latch at slot start, write buffer, frame commit and output pins.
  always_ff @(posedge m_clk) begin
    if (Reset) begin
      r_bri        <= '0;
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_act_en     <= '0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_en    <= '0;
      r_wr_ready   <= 1'b1;
      r_vcc        <= ANODE_OFF;
      r_counter    <= 8'hFF;
      r_frame_tick <= 1'b0;
    end else begin
      if (r_slot_cnt == '0) r_bri <= brightness;
      // A full buffer commits on frame_tick; a write that collides with that commit is dropped.
      if (r_frame_tick && !r_wr_ready) begin
        r_act_data <= r_pend_data;
        r_act_dp   <= r_pend_dp;
        r_act_en   <= r_pend_en;
        r_wr_ready <= 1'b1;
      end else if (wr_en && r_wr_ready) begin
        r_pend_data <= wr_data;
        r_pend_dp   <= wr_dp;
        r_pend_en   <= wr_en_dig;
        r_wr_ready  <= 1'b0;
      end
      r_vcc        <= w_vcc_nxt;
      r_counter    <= w_counter_nxt;
      r_frame_tick <= w_ftick_nxt;
    end
  end

  assign wr_ready   = r_wr_ready;
  assign vcc        = r_vcc;
  assign counter    = r_counter;
  assign frame_tick = r_frame_tick;

  // Expose the live scan position and phase.
  always_comb begin
    o_dbg.dig_idx = r_dig_idx;
    o_dbg.state   = r_state;
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler with a cycle-level reference model
// feeding an expected-value queue.
module tb_seg_scan_scheduler;
  import seg_pkg::*;

  localparam int BLANK = 2;
  localparam int STEP  = 1;
  localparam int SLOT  = BLANK + 16 * STEP;

  // ---------------- clock / reset ----------------
  logic m_clk = 1'b0;
  always #5 m_clk = ~m_clk;

  logic        Reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_dp = '0;
  logic [3:0]  wr_en_dig = '0;
  logic [3:0]  brightness = '0;
  logic        wr_ready;
  logic [3:0]  vcc;
  logic [7:0]  counter;
  logic        frame_tick;
  scan_dbg_t   o_dbg;

  seg_scan_scheduler #(.BLANK_CYCLES(BLANK), .STEP_CYCLES(STEP)) dut (
    .m_clk      (m_clk),
    .Reset      (Reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_en_dig  (wr_en_dig),
    .brightness (brightness),
    .wr_ready   (wr_ready),
    .vcc        (vcc),
    .counter    (counter),
    .frame_tick (frame_tick),
    .o_dbg      (o_dbg)
  );

  // ---------------- scoreboard state ----------------
  // Packed as {dig_idx[1:0], on_phase, frame_tick, wr_ready, vcc[3:0], counter[7:0]}.
  logic [16:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  logic [6:0] tb_lut [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  // Reference model state (scan position, buffers, currently driven frame_tick).
  int          m_s, m_dig;
  logic [3:0]  m_bri;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_act_en, m_pend_dp, m_pend_en;
  logic        m_ready, m_ftick;

  int          lit_cycles;
  logic [3:0]  pa_v, pb_v;
  logic [7:0]  pa_c, pb_c;
  int          pa_n, pb_n;

  // ---------------- reference model ----------------
  task automatic model_advance(output logic [16:0] e);
    logic       lit;
    logic [3:0] nib, v;
    logic [7:0] c;
    logic       nft;
    if (Reset) begin
      m_s = 0; m_dig = 0; m_bri = '0;
      m_act = '0; m_act_dp = '0; m_act_en = '0;
      m_pend = '0; m_pend_dp = '0; m_pend_en = '0;
      m_ready = 1'b1; m_ftick = 1'b0;
      e = {2'd0, 1'b0, 1'b0, 1'b1, 4'hF, 8'hFF};
      return;
    end
    lit = (m_s >= BLANK) && ((m_s - BLANK) < (int'(m_bri) + 1) * STEP) && m_act_en[m_dig];
    nib = m_act[m_dig*4 +: 4];
    v = 4'hF;
    c = 8'hFF;
    if (lit) begin
      v[m_dig] = 1'b0;
      c = {~m_act_dp[m_dig], tb_lut[nib]};
    end
    nft = (m_dig == 3) && (m_s == SLOT - 1);
    if (m_ftick && !m_ready) begin
      m_act = m_pend; m_act_dp = m_pend_dp; m_act_en = m_pend_en;
      m_ready = 1'b1;
    end else if (wr_en && m_ready) begin
      m_pend = wr_data; m_pend_dp = wr_dp; m_pend_en = wr_en_dig;
      m_ready = 1'b0;
    end
    if (m_s == 0) m_bri = brightness;
    if (m_s == SLOT - 1) begin
      m_s = 0;
      m_dig = (m_dig + 1) % 4;
    end else begin
      m_s = m_s + 1;
    end
    m_ftick = nft;
    e = {2'(m_dig), (m_s >= BLANK), nft, m_ready, v, c};
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [16:0] e, got, exp_v;
    model_advance(e);
    exp_q.push_back(e);
    @(posedge m_clk);
    #1;
    got   = {o_dbg, frame_tick, wr_ready, vcc, counter};
    exp_v = exp_q.pop_front();
    tests++;
    assert (got === exp_v) else begin
      fails++;
      $error("FAIL pins t=%0t got %h exp %h", $time, got, exp_v);
    end
    if (vcc !== 4'hF) lit_cycles++;
    if (vcc === pa_v && counter === pa_c) pa_n++;
    if (vcc === pb_v && counter === pb_c) pb_n++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_frame_start();
    int g = 0;
    do begin
      step();
      g++;
    end while (!(m_s == 0 && m_dig == 0) && g < 200);
  endtask

  task automatic wait_ftick();
    int g = 0;
    while (!m_ftick && g < 200) begin
      step();
      g++;
    end
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    wr_en = 1'b1; wr_data = d; wr_dp = dp; wr_en_dig = en;
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_int(input string tag, input int got, input int exp_v);
    tests++;
    assert (got === exp_v) else begin
      fails++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp_v);
    end
  endtask

  task automatic set_patterns(input logic [3:0] av, input logic [7:0] ac,
                              input logic [3:0] bv, input logic [7:0] bc);
    pa_v = av; pa_c = ac; pb_v = bv; pb_c = bc;
    pa_n = 0; pb_n = 0; lit_cycles = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    set_patterns(4'h0, 8'h00, 4'h0, 8'h00);

    // Reset held for three cycles, then a dark frame.
    run(3);
    Reset = 1'b0;
    lit_cycles = 0;
    run(SLOT * 4);
    check_int("dark_frame", lit_cycles, 0);

    // 1234, dp on digit0, all enabled, full brightness.
    brightness = 4'd15;
    write(16'h1234, 4'b0001, 4'hF);
    run_to_frame_start();
    run_to_frame_start();
    set_patterns(4'b1110, 8'h4C, 4'b0111, 8'hCF);
    run(SLOT * 4);
    check_int("dig0_on", pa_n, 16);
    check_int("dig3_on", pb_n, 16);
    check_int("full_duty", lit_cycles, 64);

    // Minimum and mid brightness duty.
    brightness = 4'd0;
    run_to_frame_start();
    lit_cycles = 0;
    run(SLOT * 4);
    check_int("duty_b0", lit_cycles, 4);
    brightness = 4'd7;
    run_to_frame_start();
    lit_cycles = 0;
    run(SLOT * 4);
    check_int("duty_b7", lit_cycles, 32);

    // Writes while pending are dropped, including one on the commit cycle.
    brightness = 4'd15;
    write(16'h5678, 4'b0010, 4'hF);
    write(16'h9999, 4'b0000, 4'hF);
    write(16'h9999, 4'b0000, 4'hF);
    wait_ftick();
    write(16'hABCD, 4'b0000, 4'hF);
    run_to_frame_start();
    set_patterns(4'b1101, 8'h0F, 4'b1110, 8'h8C);
    run(SLOT * 4);
    check_int("commit_first", pa_n, 16);
    check_int("ignored_write", pb_n, 0);

    // Write on frame_tick while empty: captured now, committed one frame later.
    wait_ftick();
    write(16'h00A0, 4'b0000, 4'b1011);
    set_patterns(4'b1101, 8'hFF, 4'b1011, 8'hFF);
    run(SLOT * 4 - 1);
    check_int("not_yet_committed", pa_n, 0);
    run_to_frame_start();
    set_patterns(4'b1101, 8'hFF, 4'b1011, 8'hFF);
    lit_cycles = 0;
    run(SLOT * 4);
    check_int("blank_nibble_lit", pa_n, 16);
    check_int("disabled_dig2", pb_n, 0);
    check_int("three_digits", lit_cycles, 48);

    // Reset mid-ON of digit2 clears committed data.
    write(16'h8888, 4'b0000, 4'hF);
    run_to_frame_start();
    begin
      int g = 0;
      while (!(m_dig == 2 && m_s == 10) && g < 200) begin
        step();
        g++;
      end
    end
    Reset = 1'b1;
    step();
    tests++;
    assert (vcc === 4'hF) else begin fails++; $error("FAIL rst_vcc got %h exp %h", vcc, 4'hF); end
    tests++;
    assert (counter === 8'hFF) else begin fails++; $error("FAIL rst_counter got %h exp %h", counter, 8'hFF); end
    tests++;
    assert (wr_ready === 1'b1) else begin fails++; $error("FAIL rst_ready got %b exp 1", wr_ready); end
    tests++;
    assert (o_dbg.dig_idx === 2'd0) else begin fails++; $error("FAIL rst_dig got %0d exp 0", o_dbg.dig_idx); end
    Reset = 1'b0;
    lit_cycles = 0;
    run(SLOT * 4);
    check_int("cleared_after_reset", lit_cycles, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
